// File: rtl/aq_cp0_cacheop_seq.sv
// aq_cp0_cacheop_seq: sequences special cache ops onto the L1 dcache then icache maintenance ports
module aq_cp0_cacheop_seq #(
    parameter int ADDR_WIDTH = 40
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  special_dcacheop_req,
    input  logic                  special_icacheop_req,
    input  logic [1:0]            special_cacheop_type,
    input  logic [1:0]            special_cacheop_op,
    input  logic [ADDR_WIDTH-1:0] iui_special_cache_addr,
    output logic                  cp0_dcache_req,
    output logic [1:0]            cp0_dcache_type,
    output logic [1:0]            cp0_dcache_op,
    output logic [ADDR_WIDTH-1:0] cp0_dcache_addr,
    input  logic                  dcache_cp0_ack,
    input  logic                  dcache_cp0_done,
    output logic                  cp0_icache_req,
    output logic [1:0]            cp0_icache_type,
    output logic [ADDR_WIDTH-1:0] cp0_icache_addr,
    input  logic                  icache_cp0_ack,
    input  logic                  icache_cp0_done,
    output logic                  cp0_iu_cacheop_busy,
    output logic                  cp0_iu_cacheop_done
);
    typedef enum logic [2:0] {IDLE, DREQ, DWAIT, IREQ, IWAIT, CMPLT} state_t;
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_CLN = 2'b10;
    state_t                  state, state_nxt;
    logic                    need_i;
    logic [1:0]              type_q, op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    accept, need_i_in;
    assign accept    = (state == IDLE) && (special_dcacheop_req || special_icacheop_req);
    assign need_i_in = special_icacheop_req && (special_cacheop_op != OP_CLN);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)
                         state_nxt = (special_cacheop_op == OP_NOP) ? CMPLT :
                                     special_dcacheop_req ? DREQ : need_i_in ? IREQ : CMPLT;
            DREQ:    if (dcache_cp0_ack)
                         state_nxt = !dcache_cp0_done ? DWAIT : need_i ? IREQ : CMPLT;
            DWAIT:   if (dcache_cp0_done) state_nxt = need_i ? IREQ : CMPLT;
            IREQ:    if (icache_cp0_ack) state_nxt = icache_cp0_done ? CMPLT : IWAIT;
            IWAIT:   if (icache_cp0_done) state_nxt = CMPLT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state  <= IDLE;
            need_i <= 1'b0;
            type_q <= 2'b00;
            op_q   <= 2'b00;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                need_i <= need_i_in;
                type_q <= special_cacheop_type;
                op_q   <= special_cacheop_op;
                addr_q <= iui_special_cache_addr;
            end
        end
    end
    assign cp0_dcache_req      = (state == DREQ);
    assign cp0_icache_req      = (state == IREQ);
    assign cp0_dcache_type     = type_q;
    assign cp0_dcache_op       = op_q;
    assign cp0_dcache_addr     = addr_q;
    assign cp0_icache_type     = type_q;
    assign cp0_icache_addr     = addr_q;
    assign cp0_iu_cacheop_busy = (state != IDLE);
    assign cp0_iu_cacheop_done = (state == CMPLT);
endmodule

// File: tb/tb_aq_cp0_cacheop_seq.sv
// tb_aq_cp0_cacheop_seq: directed stimulus with an event scoreboard on req/done/busy pulses
module tb_aq_cp0_cacheop_seq;
    logic        clk = 1'b0, rst = 1'b1;
    logic        dr = 1'b0, ir = 1'b0;
    logic [1:0]  ty = 2'b00, op = 2'b00;
    logic [39:0] ad = '0;
    logic        dack = 1'b0, ddone = 1'b0, iack = 1'b0, idone = 1'b0;
    logic        d_req, i_req, busy, done;
    logic [1:0]  d_type, d_op, i_type;
    logic [39:0] d_addr, i_addr;
    int          cyc = 0, vectors = 0, miscompares = 0;
    bit          mon_en = 1'b0;

    aq_cp0_cacheop_seq #(.ADDR_WIDTH(40)) dut (
        .forever_cpuclk(clk), .cpurst(rst),
        .special_dcacheop_req(dr), .special_icacheop_req(ir),
        .special_cacheop_type(ty), .special_cacheop_op(op),
        .iui_special_cache_addr(ad),
        .cp0_dcache_req(d_req), .cp0_dcache_type(d_type), .cp0_dcache_op(d_op),
        .cp0_dcache_addr(d_addr), .dcache_cp0_ack(dack), .dcache_cp0_done(ddone),
        .cp0_icache_req(i_req), .cp0_icache_type(i_type), .cp0_icache_addr(i_addr),
        .icache_cp0_ack(iack), .icache_cp0_done(idone),
        .cp0_iu_cacheop_busy(busy), .cp0_iu_cacheop_done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 dcache req, 1 icache req, 2 done pulse, 3 busy window
    typedef struct {
        int          kind;
        int          start;
        int          len;
        logic [1:0]  typ;
        logic [1:0]  op;
        logic [39:0] addr;
    } ev_t;
    ev_t exp_q[$];

    function automatic ev_t mk(int k, int s, int l, logic [1:0] t, logic [1:0] o, logic [39:0] a);
        ev_t e;
        e.kind = k; e.start = s; e.len = l; e.typ = t; e.op = o; e.addr = a;
        return e;
    endfunction

    logic prev [4];
    int   st [4];
    ev_t  cap [4];
    initial for (int k = 0; k < 4; k++) prev[k] = 1'b0;

    always @(negedge clk) begin
        logic [3:0] sig;
        ev_t        got, want;
        sig = {busy, done, i_req, d_req};
        if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
                if (sig[k] && !prev[k]) begin
                    st[k] = cyc;
                    cap[k] = (k == 0) ? mk(0, cyc, 0, d_type, d_op, d_addr) :
                             (k == 1) ? mk(1, cyc, 0, i_type, 2'b00, i_addr) :
                                        mk(k, cyc, 0, 2'b00, 2'b00, 40'h0);
                end
                if (!sig[k] && prev[k]) begin
                    got = cap[k];
                    got.len = cyc - st[k];
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected event kind=%0d start=%0d len=%0d", got.kind, got.start, got.len);
                    end else begin
                        want = exp_q.pop_front();
                        if (got != want) begin
                            miscompares++;
                            $display("FAIL event got kind=%0d start=%0d len=%0d type=%b op=%b addr=%h, want kind=%0d start=%0d len=%0d type=%b op=%b addr=%h",
                                     got.kind, got.start, got.len, got.typ, got.op, got.addr,
                                     want.kind, want.start, want.len, want.typ, want.op, want.addr);
                        end
                    end
                end
                prev[k] = sig[k];
            end
        end
    end

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // ka/kd: cycles after dcache req rises for ack/done; ia/id likewise for icache
    task automatic run_op(input logic d, input logic i, input logic [1:0] t, input logic [1:0] o,
                          input logic [39:0] a, input int ka, input int kd, input int ia, input int id);
        int  acc, dend, fin, c;
        bit  nd, ni;
        @(negedge clk); #1;
        acc = cyc + 1;
        nd = d && (o != 2'b00);
        ni = i && (o != 2'b00) && (o != 2'b10) && !(d && o == 2'b00);
        if (nd) exp_q.push_back(mk(0, acc, ka + 1, t, o, a));
        dend = nd ? acc + kd + 1 : acc;
        if (ni) exp_q.push_back(mk(1, dend, ia + 1, t, 2'b00, a));
        fin = ni ? dend + id + 1 : dend;
        exp_q.push_back(mk(2, fin, 1, 2'b00, 2'b00, 40'h0));
        exp_q.push_back(mk(3, acc, fin - acc + 1, 2'b00, 2'b00, 40'h0));
        dr = d; ir = i; ty = t; op = o; ad = a;
        for (int k = 0; k < fin - acc + 3; k++) begin
            @(negedge clk); #1;
            c = cyc;
            dr = 1'b0; ir = 1'b0;
            dack  = nd && (c == acc + ka);
            ddone = nd && (c == acc + kd);
            iack  = ni && (c == dend + ia);
            idone = ni && (c == dend + id);
        end
        dack = 1'b0; ddone = 1'b0; iack = 1'b0; idone = 1'b0;
    endtask

    initial begin
        int acc;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_dreq", {63'h0, d_req}, 64'h0);
        chk("rst_ireq", {63'h0, i_req}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_fields", {18'h0, d_type, d_op, i_type, d_addr}, 64'h0);
        chk("rst_iaddr", {24'h0, i_addr}, 64'h0);
        #1 rst = 1'b0;
        @(negedge clk); mon_en = 1'b1;

        run_op(1, 0, 2'b10, 2'b11, 40'h12_3456_7000, 1, 4, 0, 0);
        run_op(1, 1, 2'b00, 2'b01, 40'h00_0000_0040, 0, 2, 1, 3);
        run_op(0, 1, 2'b01, 2'b10, 40'h00_0000_0123, 0, 0, 0, 0);
        run_op(1, 1, 2'b11, 2'b10, 40'hab_cdef_0000, 0, 1, 0, 0);
        run_op(1, 0, 2'b10, 2'b00, 40'h55_5555_5555, 0, 0, 0, 0);
        run_op(1, 0, 2'b10, 2'b01, 40'h00_dead_bee0, 0, 0, 0, 0);
        run_op(0, 1, 2'b10, 2'b11, 40'hff_ffff_ffc0, 0, 0, 0, 0);

        // stray done pulse while idle must not start anything
        @(negedge clk); #1 ddone = 1'b1;
        @(negedge clk); #1 ddone = 1'b0;
        repeat (2) @(negedge clk);

        // reset while waiting for dcache done; a later done is ignored
        @(negedge clk); #1;
        acc = cyc + 1;
        exp_q.push_back(mk(0, acc, 1, 2'b11, 2'b01, 40'h01_2345_6780));
        exp_q.push_back(mk(3, acc, 3, 2'b00, 2'b00, 40'h0));
        dr = 1'b1; ty = 2'b11; op = 2'b01; ad = 40'h01_2345_6780;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            dr    = 1'b0;
            dack  = (cyc == acc);
            rst   = (cyc == acc + 2);
            ddone = (cyc == acc + 4);
        end
        chk("post_rst_busy", {63'h0, busy}, 64'h0);
        chk("post_rst_addr", {24'h0, d_addr}, 64'h0);
        run_op(1, 1, 2'b00, 2'b11, 40'h33_0000_1000, 2, 3, 0, 2);

        repeat (3) @(negedge clk);
        chk("pending_events", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
